// File: rtl/pipelined_cla_adder_pkg.sv
// rtl/pipelined_cla_adder_pkg.sv - op encoding, parameter legality and lookahead carry helper
package pipelined_cla_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_ADC = 2'd1,
        OP_SUB = 2'd2,
        OP_SBB = 2'd3
    } op_e;

    localparam int LA_MAX = 64;

    function automatic bit params_ok(input int width, input int group, input int stages);
        return (group > 0) && (stages >= 1) && (group <= LA_MAX) &&
               (width % (stages * group) == 0) && (width / (stages * group) <= LA_MAX);
    endfunction

    // Carry after n positions as a flat sum of products: c*P[n-1:0] | G[i]*P[n-1:i+1].
    function automatic logic la_carry(input logic [LA_MAX-1:0] p, input logic [LA_MAX-1:0] g,
                                      input logic c, input int n);
        logic acc;
        logic term;
        acc = c;
        for (int i = 0; i < n; i++) acc = acc & p[i];
        for (int i = 0; i < n; i++) begin
            term = g[i];
            for (int m = i + 1; m < n; m++) term = term & p[m];
            acc = acc | term;
        end
        return acc;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// rtl/pipelined_cla_adder_cla_group.sv - combinational GROUP-bit carry-lookahead group
module cla_group
    import pipelined_cla_adder_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             pg,
    output logic             gg,
    output logic             co
);

    logic [GROUP-1:0] c;

    always_comb begin
        c = '0;
        for (int i = 0; i < GROUP; i++) c[i] = la_carry(LA_MAX'(p), LA_MAX'(g), ci, i);
    end

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = la_carry(LA_MAX'(p), LA_MAX'(g), 1'b0, GROUP);
    assign co = la_carry(LA_MAX'(p), LA_MAX'(g), ci, GROUP);

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshakes
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int S  = WIDTH / STAGES;
    localparam int NG = S / GROUP;
    localparam int L  = STAGES - 1;

    if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*GROUP");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        b_eff = op[1] ? ~b : b;
        case (op_e'(op))
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            default: c0 = cin;
        endcase
    end

    // Each stage carries only the operand bits still to be added and the sum bits already done.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic                 v_i;
        logic                 c_i;
        logic                 c_o;
        logic [WIDTH-1:k*S]   a_up;
        logic [WIDTH-1:k*S]   b_up;
        logic [S-1:0]         p;
        logic [S-1:0]         g;
        logic [S-1:0]         s_s;
        logic [(k+1)*S-1:0]   s_acc;
        logic [NG-1:0]        gp;
        logic [NG-1:0]        gg;
        logic [NG-1:0]        gc;
        logic [NG-1:0]        grp_co;
        logic                 co_unused;

        if (k == 0) begin : g_head
            assign v_i   = in_valid;
            assign c_i   = c0;
            assign a_up  = a;
            assign b_up  = b_eff;
            assign s_acc = s_s;
        end else begin : g_reg
            logic                 v_q;
            logic                 c_q;
            logic [WIDTH-1:k*S]   a_q;
            logic [WIDTH-1:k*S]   b_q;
            logic [k*S-1:0]       s_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (adv) begin
                    v_q <= g_st[k-1].v_i;
                    c_q <= g_st[k-1].c_o;
                    a_q <= g_st[k-1].a_up[WIDTH-1:k*S];
                    b_q <= g_st[k-1].b_up[WIDTH-1:k*S];
                    s_q <= g_st[k-1].s_acc;
                end
            end

            assign v_i   = v_q;
            assign c_i   = c_q;
            assign a_up  = a_q;
            assign b_up  = b_q;
            assign s_acc = {s_s, s_q};
        end

        assign p = a_up[k*S +: S] ^ b_up[k*S +: S];
        assign g = a_up[k*S +: S] & b_up[k*S +: S];

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(.GROUP(GROUP)) u_grp (
                .p  (p[j*GROUP +: GROUP]),
                .g  (g[j*GROUP +: GROUP]),
                .ci (gc[j]),
                .s  (s_s[j*GROUP +: GROUP]),
                .pg (gp[j]),
                .gg (gg[j]),
                .co (grp_co[j])
            );
        end

        // Block-level lookahead: group carries come from group P/G, never from the previous group's co.
        always_comb begin
            gc = '0;
            for (int n = 0; n < NG; n++) gc[n] = la_carry(LA_MAX'(gp), LA_MAX'(gg), c_i, n);
        end

        assign c_o       = la_carry(LA_MAX'(gp), LA_MAX'(gg), c_i, NG);
        assign co_unused = ^grp_co;
    end

    logic [WIDTH-1:0] sum_d;
    logic             c_msb;

    assign sum_d = g_st[L].s_acc;
    assign c_msb = sum_d[WIDTH-1] ^ g_st[L].p[S-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= g_st[L].v_i;
            sum       <= sum_d;
            cout      <= g_st[L].c_o;
            ovf       <= c_msb ^ g_st[L].c_o;
            zero      <= ~|sum_d;
        end
    end

endmodule
